ring_sldu_endpoint: RTL and testbench

// - SLDU-side endpoint of the inter-cluster ring router.
// - Accepts one slide/reduction ring command at a time and issues a single-cycle configuration pulse
//   (dir, bypass) to the router.
// - Streams tx_len words from the SLDU datapath into the router and collects rx_len words from it.
// - Pulses done_o once all traffic has drained.

---
 rtl/ring_sldu_endpoint_pkg.sv | 23 ++
 rtl/ring_sldu_endpoint_spill.sv | 53 +++++
 rtl/ring_sldu_endpoint.sv | 152 +++++++++++++++
 tb/tb_ring_sldu_endpoint.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_sldu_endpoint_pkg.sv
// Shared types for the SLDU-side ring endpoint: command layout, FSM states, widths.
package ring_sldu_endpoint_pkg;

  localparam int unsigned RingCntWidth = 16;
  localparam int unsigned ElenWidth    = 64;

  typedef logic [ElenWidth-1:0] elen_t;

  typedef struct packed {
    logic                    dir;
    logic                    bypass;
    logic [RingCntWidth-1:0] tx_len;
    logic [RingCntWidth-1:0] rx_len;
  } ring_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    CONF,
    XFER,
    DONE
  } ring_state_e;

endpackage

// File: rtl/ring_sldu_endpoint_spill.sv
// Two-entry spill register: fully registered valid/data, one-cycle latency,
// full throughput, order preserving.
module ring_sldu_endpoint_spill #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             a_full_q, a_full_d;
  logic             b_full_q, b_full_d;
  logic [Width-1:0] a_data_q, a_data_d;
  logic [Width-1:0] b_data_q, b_data_d;
  logic             a_fill, a_drain, b_fill, b_drain;

  // Slot A takes new words; it spills into slot B when the consumer stalls.
  always_comb begin
    a_fill   = valid_i & ready_o;
    a_drain  = a_full_q & ~b_full_q;
    b_fill   = a_drain & ~ready_i;
    b_drain  = b_full_q & ready_i;
    a_full_d = a_fill | (a_full_q & ~a_drain);
    a_data_d = a_fill ? data_i : a_data_q;
    b_full_d = b_fill | (b_full_q & ~b_drain);
    b_data_d = b_fill ? a_data_q : b_data_q;
  end

  // Storage flops; reset empties both slots.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
    end
  end

  assign ready_o = ~a_full_q | ~b_full_q;
  assign valid_o = a_full_q | b_full_q;
  assign data_o  = b_full_q ? b_data_q : a_data_q;

endmodule

// File: rtl/ring_sldu_endpoint.sv
// SLDU-side endpoint of the inter-cluster ring: takes one command, pulses the
// router configuration, streams tx words out, collects rx words, signals done.
module ring_sldu_endpoint
  import ring_sldu_endpoint_pkg::*;
#(
  parameter int unsigned DataWidth = $bits(elen_t),
  parameter int unsigned CntWidth  = RingCntWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  ring_cmd_t            cmd_i,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [DataWidth-1:0] ring_data_o,
  output logic                 ring_valid_o,
  input  logic                 ring_ready_i,
  input  logic [DataWidth-1:0] ring_data_i,
  input  logic                 ring_valid_i,
  output logic                 ring_ready_o,
  output logic                 conf_dir_o,
  output logic                 conf_bypass_o,
  output logic                 conf_valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  ring_state_e         state_q, state_d;
  logic [CntWidth-1:0] tx_len_q, tx_len_d;
  logic [CntWidth-1:0] rx_len_q, rx_len_d;
  logic [CntWidth-1:0] tx_cnt_q, tx_cnt_d;
  logic [CntWidth-1:0] rx_cnt_q, rx_cnt_d;
  logic                conf_dir_q, conf_dir_d;
  logic                conf_bypass_q, conf_bypass_d;
  logic                conf_valid_q, conf_valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                tx_gate, rx_gate;
  logic                tx_buf_ready, rx_buf_ready;

  assign tx_gate      = (state_q == XFER) && (tx_cnt_q != tx_len_q);
  assign rx_gate      = (state_q == XFER) && (rx_cnt_q != rx_len_q);
  assign tx_ready_o   = tx_buf_ready & tx_gate;
  assign ring_ready_o = rx_buf_ready & rx_gate;

  ring_sldu_endpoint_spill #(.Width(DataWidth)) i_tx_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (tx_valid_i & tx_gate),
    .ready_o (tx_buf_ready),
    .data_i  (tx_data_i),
    .valid_o (ring_valid_o),
    .ready_i (ring_ready_i),
    .data_o  (ring_data_o)
  );

  ring_sldu_endpoint_spill #(.Width(DataWidth)) i_rx_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (ring_valid_i & rx_gate),
    .ready_o (rx_buf_ready),
    .data_i  (ring_data_i),
    .valid_o (rx_valid_o),
    .ready_i (rx_ready_i),
    .data_o  (rx_data_o)
  );

  // Next-state, counter and held-configuration logic for the command FSM.
  always_comb begin
    state_d       = state_q;
    tx_len_d      = tx_len_q;
    rx_len_d      = rx_len_q;
    tx_cnt_d      = tx_cnt_q;
    rx_cnt_d      = rx_cnt_q;
    conf_dir_d    = conf_dir_q;
    conf_bypass_d = conf_bypass_q;
    if (tx_valid_i && tx_ready_o) tx_cnt_d = tx_cnt_q + CntWidth'(1);
    if (ring_valid_i && ring_ready_o) rx_cnt_d = rx_cnt_q + CntWidth'(1);
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          tx_len_d      = cmd_i.tx_len;
          rx_len_d      = cmd_i.rx_len;
          conf_dir_d    = cmd_i.dir;
          conf_bypass_d = cmd_i.bypass;
          state_d       = CONF;
        end
      end
      CONF: begin
        if (conf_bypass_q || ((tx_len_q == '0) && (rx_len_q == '0))) state_d = DONE;
        else state_d = XFER;
      end
      XFER: begin
        if ((tx_cnt_q == tx_len_q) && (rx_cnt_q == rx_len_q) && !ring_valid_o && !rx_valid_o)
          state_d = DONE;
      end
      DONE: begin
        tx_cnt_d = '0;
        rx_cnt_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    conf_valid_d = (state_d == CONF);
    done_d       = (state_d == DONE);
    busy_d       = (state_d != IDLE);
    cmd_ready_d  = (state_d == IDLE);
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      tx_len_q      <= '0;
      rx_len_q      <= '0;
      tx_cnt_q      <= '0;
      rx_cnt_q      <= '0;
      conf_dir_q    <= 1'b0;
      conf_bypass_q <= 1'b0;
      conf_valid_q  <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      tx_len_q      <= tx_len_d;
      rx_len_q      <= rx_len_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      conf_dir_q    <= conf_dir_d;
      conf_bypass_q <= conf_bypass_d;
      conf_valid_q  <= conf_valid_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign conf_dir_o    = conf_dir_q;
  assign conf_bypass_o = conf_bypass_q;
  assign conf_valid_o  = conf_valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_ring_sldu_endpoint.sv
// Self-checking bench for ring_sldu_endpoint: transaction-level model with
// per-cycle compare, directed scenarios and randomized commands.
module tb_ring_sldu_endpoint;
  import ring_sldu_endpoint_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_ni;
  logic      cmd_valid_i;
  logic      cmd_ready_o;
  ring_cmd_t cmd_i;
  elen_t     tx_data_i;
  logic      tx_valid_i;
  logic      tx_ready_o;
  elen_t     rx_data_o;
  logic      rx_valid_o;
  logic      rx_ready_i;
  elen_t     ring_data_o;
  logic      ring_valid_o;
  logic      ring_ready_i;
  elen_t     ring_data_i;
  logic      ring_valid_i;
  logic      ring_ready_o;
  logic      conf_dir_o, conf_bypass_o, conf_valid_o, busy_o, done_o;

  // bench-side drive of the router-facing inputs, optionally looped back
  logic  loopback = 1'b0;
  logic  drvRingValid, drvRingReady;
  elen_t drvRingData;
  assign ring_valid_i = loopback ? ring_valid_o : drvRingValid;
  assign ring_data_i  = loopback ? ring_data_o  : drvRingData;
  assign ring_ready_i = loopback ? ring_ready_o : drvRingReady;

  ring_sldu_endpoint dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .ring_data_o(ring_data_o), .ring_valid_o(ring_valid_o), .ring_ready_i(ring_ready_i),
    .ring_data_i(ring_data_i), .ring_valid_i(ring_valid_i), .ring_ready_o(ring_ready_o),
    .conf_dir_o(conf_dir_o), .conf_bypass_o(conf_bypass_o), .conf_valid_o(conf_valid_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int errCnt = 0;
  int chkCnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model (written only by the monitor) ----------------
  int        mPhase = 0;          // 0 idle, 1 configuring, 2 transferring, 3 finished
  ring_cmd_t mCmd = '0;
  int        mTxCnt = 0, mRxCnt = 0;
  elen_t     txQ[$];              // words accepted from SLDU, not yet handed to router
  elen_t     rxQ[$];              // words accepted from router, not yet handed to SLDU
  logic      mConfDir = 1'b0, mConfBypass = 1'b0;
  // event log for directed expectations
  int        acceptCnt = 0, doneCount = 0, ringOutCnt = 0, ringInCnt = 0;
  int        txReadyCnt = 0, ringReadyLowCnt = 0;
  int        acceptCyc = 0, confCyc = 0, doneCyc = 0, lastTxHsCyc = 0, lastRxHsCyc = 0;
  logic      confDirSeen = 1'b0, confBypSeen = 1'b0;
  elen_t     rxLog[$];

  task automatic modelReset();
    mPhase = 0; mCmd = '0; mTxCnt = 0; mRxCnt = 0;
    txQ.delete(); rxQ.delete();
    mConfDir = 1'b0; mConfBypass = 1'b0;
  endtask

  task automatic modelStep(input logic eTx, input logic eRR, input logic eRV, input logic eXV);
    int nextPhase = mPhase;
    case (mPhase)
      0: if (cmd_valid_i) begin
           mCmd = cmd_i; mConfDir = cmd_i.dir; mConfBypass = cmd_i.bypass;
           nextPhase = 1; acceptCnt++; acceptCyc = cyc;
         end
      1: nextPhase = (mCmd.bypass || (mCmd.tx_len == 0 && mCmd.rx_len == 0)) ? 3 : 2;
      2: if (mTxCnt == int'(mCmd.tx_len) && mRxCnt == int'(mCmd.rx_len) &&
             txQ.size() == 0 && rxQ.size() == 0) nextPhase = 3;
      default: begin nextPhase = 0; mTxCnt = 0; mRxCnt = 0; end
    endcase
    if (mPhase == 2 && !ring_ready_o && mRxCnt < int'(mCmd.rx_len)) ringReadyLowCnt++;
    if (eRV && ring_ready_i) begin void'(txQ.pop_front()); ringOutCnt++; end
    if (eXV && rx_ready_i) begin rxLog.push_back(rx_data_o); void'(rxQ.pop_front()); lastRxHsCyc = cyc; end
    if (tx_valid_i && eTx) begin txQ.push_back(tx_data_i); mTxCnt++; lastTxHsCyc = cyc; end
    if (ring_valid_i && eRR) begin rxQ.push_back(ring_data_i); mRxCnt++; ringInCnt++; end
    if (done_o) begin doneCount++; doneCyc = cyc; end
    if (conf_valid_o) begin confCyc = cyc; confDirSeen = conf_dir_o; confBypSeen = conf_bypass_o; end
    if (tx_ready_o) txReadyCnt++;
    mPhase = nextPhase;
  endtask

  // compare process: every cycle, outputs sampled mid-cycle against the model
  always @(negedge clk_i) begin
    logic eTx, eRR, eRV, eXV;
    if (!rst_ni) modelReset();
    eRV = (txQ.size() > 0);
    eXV = (rxQ.size() > 0);
    eTx = (mPhase == 2) && (mTxCnt != int'(mCmd.tx_len)) && (txQ.size() < 2);
    eRR = (mPhase == 2) && (mRxCnt != int'(mCmd.rx_len)) && (rxQ.size() < 2);
    checkOutput("cmd_ready", cmd_ready_o, mPhase == 0);
    checkOutput("busy", busy_o, mPhase != 0);
    checkOutput("conf_valid", conf_valid_o, mPhase == 1);
    checkOutput("conf_dir", conf_dir_o, mConfDir);
    checkOutput("conf_bypass", conf_bypass_o, mConfBypass);
    checkOutput("done", done_o, mPhase == 3);
    checkOutput("tx_ready", tx_ready_o, eTx);
    checkOutput("ring_ready", ring_ready_o, eRR);
    checkOutput("ring_valid", ring_valid_o, eRV);
    checkOutput("rx_valid", rx_valid_o, eXV);
    if (eRV) checkOutput("ring_data", ring_data_o, txQ[0]);
    if (eXV) checkOutput("rx_data", rx_data_o, rxQ[0]);
    if (rst_ni) modelStep(eTx, eRR, eRV, eXV);
  end

  // ---------------- stimulus ----------------
  int        issuedCnt = 0;
  ring_cmd_t pendCmd = '0;
  elen_t     txBase = '0;
  int        tcyc = 0;
  int        txValidPct = 100, ringValidPct = 0, ringReadyMode = 0, rxReadyPct = 100;
  int        rxLoFrom = 1000000, rxLoTo = 0;

  task automatic applyStimulus();
    @(posedge clk_i); #1;
    tcyc++;
    cmd_valid_i  = (acceptCnt < issuedCnt);
    cmd_i        = pendCmd;
    tx_valid_i   = ($urandom_range(99) < txValidPct);
    tx_data_i    = txBase + 64'(mTxCnt);
    drvRingValid = ($urandom_range(99) < ringValidPct);
    drvRingData  = {$urandom, $urandom};
    case (ringReadyMode)
      0: drvRingReady = 1'b1;
      1: drvRingReady = (tcyc % 2 == 1);
      2: drvRingReady = ($urandom_range(1) == 1);
      default: drvRingReady = 1'b0;
    endcase
    rx_ready_i = (tcyc >= rxLoFrom && tcyc <= rxLoTo) ? 1'b0 : ($urandom_range(99) < rxReadyPct);
  endtask

  task automatic setKnobs(input logic lb, input int txv, input int rv, input int rrm, input int rxr,
                          input int lo, input int hi);
    loopback = lb; txValidPct = txv; ringValidPct = rv; ringReadyMode = rrm;
    rxReadyPct = rxr; rxLoFrom = lo; rxLoTo = hi;
  endtask

  task automatic startCmd(input logic dir, input logic byp, input int txl, input int rxl, input elen_t base);
    pendCmd.dir = dir; pendCmd.bypass = byp;
    pendCmd.tx_len = 16'(txl); pendCmd.rx_len = 16'(rxl);
    txBase = base; tcyc = 0; issuedCnt++;
  endtask

  task automatic runUntilDone(input int budget, input string name);
    int d0 = doneCount;
    int i = 0;
    while (i < budget && doneCount == d0) begin applyStimulus(); i++; end
    checkOutput(name, doneCount - d0, 1);
  endtask

  initial begin
    int d0, r0, o0, i0, t0, l0;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_i = '0; tx_valid_i = 1'b0; tx_data_i = '0;
    rx_ready_i = 1'b0; drvRingValid = 1'b0; drvRingReady = 1'b0; drvRingData = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_cmd_ready", cmd_ready_o, 1);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_conf_valid", conf_valid_o, 0);
    checkOutput("reset_conf_dir", conf_dir_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_ring_valid", ring_valid_o, 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (2) applyStimulus();

    // loopback of four words
    $display("[TB] loopback");
    setKnobs(1'b1, 100, 0, 0, 100, 1000000, 0);
    d0 = doneCount; r0 = rxLog.size();
    startCmd(1'b0, 1'b0, 4, 4, 64'hA0);
    runUntilDone(100, "loop_done");
    repeat (4) applyStimulus();
    checkOutput("loop_conf_latency", confCyc - acceptCyc, 1);
    checkOutput("loop_conf_dir", confDirSeen, 0);
    checkOutput("loop_rx_count", rxLog.size() - r0, 4);
    for (int k = 0; k < 4; k++)
      if (r0 + k < rxLog.size()) checkOutput("loop_rx_word", rxLog[r0 + k], 64'hA0 + 64'(k));
    // the last tx handshake closes cycle c; done_o is up three edges later, in cycle c+4
    checkOutput("loop_done_latency", doneCyc - lastTxHsCyc, 4);
    checkOutput("loop_done_once", doneCount - d0, 1);

    // backpressure on both sides
    $display("[TB] backpressure");
    setKnobs(1'b0, 100, 100, 1, 100, 3, 8);
    d0 = doneCount; r0 = rxLog.size(); o0 = ringOutCnt; i0 = ringInCnt; l0 = ringReadyLowCnt;
    startCmd(1'b0, 1'b0, 8, 8, 64'h1000);
    runUntilDone(200, "bp_done");
    checkOutput("bp_ring_ready_fell", ringReadyLowCnt > l0, 1);
    checkOutput("bp_tx_words", ringOutCnt - o0, 8);
    checkOutput("bp_rx_in_words", ringInCnt - i0, 8);
    checkOutput("bp_rx_out_words", rxLog.size() - r0, 8);

    // bypass: no data moves
    $display("[TB] bypass");
    setKnobs(1'b0, 100, 100, 0, 100, 1000000, 0);
    t0 = txReadyCnt; i0 = ringInCnt;
    startCmd(1'b1, 1'b1, 8, 8, 64'h2000);
    runUntilDone(50, "byp_done");
    checkOutput("byp_conf_bypass", confBypSeen, 1);
    checkOutput("byp_conf_dir", confDirSeen, 1);
    checkOutput("byp_done_latency", doneCyc - confCyc, 1);
    checkOutput("byp_no_tx_ready", txReadyCnt - t0, 0);
    checkOutput("byp_no_rx_words", ringInCnt - i0, 0);

    // receive only, SLDU stalled early
    $display("[TB] asymmetric");
    setKnobs(1'b0, 100, 100, 0, 100, 1, 9);
    t0 = txReadyCnt; r0 = rxLog.size();
    startCmd(1'b0, 1'b0, 0, 3, 64'h3000);
    runUntilDone(100, "asym_done");
    checkOutput("asym_no_tx_ready", txReadyCnt - t0, 0);
    checkOutput("asym_rx_words", rxLog.size() - r0, 3);
    checkOutput("asym_done_after_rx", doneCyc - lastRxHsCyc, 2);

    // reset in the middle of a transfer
    $display("[TB] abort");
    setKnobs(1'b0, 100, 0, 3, 0, 1000000, 0);
    d0 = doneCount;
    startCmd(1'b0, 1'b0, 4, 4, 64'h4000);
    for (int i = 0; i < 50 && mTxCnt < 2; i++) applyStimulus();
    checkOutput("abort_progress", mTxCnt, 2);
    rst_ni = 1'b0; tx_valid_i = 1'b0; cmd_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abort_ring_valid", ring_valid_o, 0);
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_cmd_ready", cmd_ready_o, 1);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("abort_no_done", doneCount - d0, 0);
    setKnobs(1'b0, 100, 100, 0, 100, 1000000, 0);
    startCmd(1'b0, 1'b0, 1, 1, 64'h5000);
    runUntilDone(50, "abort_followup_done");

    // randomized commands
    $display("[TB] random");
    for (int n = 0; n < 30; n++) begin
      setKnobs(1'b0, 40 + $urandom_range(60), 30 + $urandom_range(70), 2, 40 + $urandom_range(60),
               1000000, 0);
      startCmd($urandom_range(1) == 1, $urandom_range(9) == 0, $urandom_range(6), $urandom_range(6),
               {$urandom, $urandom});
      runUntilDone(600, "rand_done");
      repeat ($urandom_range(3)) applyStimulus();
    end
    repeat (3) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
